// File: rtl/chan_interleave_sched.sv
`default_nettype none
// ============================================================================
// Module   : chan_interleave_sched
// Brief    : Merges up to four strobed sample sources into one strobed stream
//            in strict channel order, with one-deep per-channel buffering and
//            sticky overrun. Optional framing outputs under macro
//            CHAN_INTERLEAVE_SCHED_FRAME_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chan_interleave_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NCHAN      = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    init,
    input  logic [3:0]              active_mask,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    input  logic [3:0]              strobe_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    strobe_out,
    output logic [1:0]              chan_out,
    output logic                    overrun
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
    ,
    output logic                    frame_start,
    output logic [15:0]             frame_count
`endif
);

    localparam logic [3:0] C_CHAN_MASK = 4'((1 << NCHAN) - 1);

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Smallest set bit strictly above p, otherwise wrap to the lowest set bit.
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] r;
        r = lowest_set(m);
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (2'(i) > p)) r = 2'(i);
        end
        return r;
    endfunction

    logic [3:0]            r_mask;
    logic [1:0]            r_ptr;
    logic [3:0]            r_valid;
    logic [DATA_WIDTH-1:0] r_hold [4];

    logic [3:0] w_mask_new;
    logic       w_clear;
    logic       w_drain;
    logic [3:0] w_drain_vec;
    logic [3:0] w_cap;
    logic       w_ovr;
    logic [3:0] w_valid_next;

    assign w_mask_new   = active_mask & C_CHAN_MASK;
    assign w_clear      = !reset_n || !enable || init;
    assign w_drain      = r_valid[r_ptr];
    assign w_drain_vec  = w_drain ? (4'b0001 << r_ptr) : 4'b0000;
    assign w_cap        = strobe_in & r_mask;
    // A capture on the channel being drained this cycle refills it without loss.
    assign w_ovr        = |(w_cap & r_valid & ~w_drain_vec);
    assign w_valid_next = w_cap | (r_valid & ~w_drain_vec);

`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
    logic [1:0] r_low_ch;
`endif

    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_mask     <= w_mask_new;
            r_ptr      <= lowest_set(w_mask_new);
            r_valid    <= 4'b0000;
            data_out   <= '0;
            strobe_out <= 1'b0;
            chan_out   <= 2'd0;
            overrun    <= 1'b0;
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
            r_low_ch    <= lowest_set(w_mask_new);
            frame_start <= 1'b0;
            frame_count <= 16'd0;
`endif
        end else begin
            r_valid <= w_valid_next;
            for (int i = 0; i < 4; i++) begin
                if (w_cap[i]) r_hold[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_ovr) overrun <= 1'b1;
            if (w_drain) begin
                data_out   <= r_hold[r_ptr];
                chan_out   <= r_ptr;
                strobe_out <= 1'b1;
                r_ptr      <= next_set(r_mask, r_ptr);
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
                frame_start <= (r_ptr == r_low_ch);
                if (r_ptr == r_low_ch) frame_count <= frame_count + 16'd1;
`endif
            end else begin
                strobe_out <= 1'b0;
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
                frame_start <= 1'b0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chan_interleave_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_interleave_sched
// Brief    : Directed and randomized bench for chan_interleave_sched against a
//            behavioural channel-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chan_interleave_sched;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n, enable, init;
    logic [3:0]    active_mask, strobe_in;
    logic [4*DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          strobe_out;
    logic [1:0]    chan_out;
    logic          overrun;
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
    logic          frame_start;
    logic [15:0]   frame_count;
`endif

    always #5 clock = ~clock;

    chan_interleave_sched #(.DATA_WIDTH(DW), .NCHAN(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .init        (init),
        .active_mask (active_mask),
        .data_in     (data_in),
        .strobe_in   (strobe_in),
        .data_out    (data_out),
        .strobe_out  (strobe_out),
        .chan_out    (chan_out),
        .overrun     (overrun)
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
        ,
        .frame_start (frame_start),
        .frame_count (frame_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0]  m_mask;
    int          m_ptr;
    logic [3:0]  m_valid;
    logic [15:0] m_hold [4];
    logic [15:0] m_data;
    logic        m_strobe;
    logic [1:0]  m_chan;
    logic        m_ovr;
    logic        m_fs;
    logic [15:0] m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int c = 0; c < 4; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int next_act(input int p, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    task automatic model_edge();
        if (!reset_n || !enable || init) begin
            m_mask   = active_mask;
            m_ptr    = lowest(m_mask);
            m_valid  = 4'b0;
            m_data   = 16'h0;
            m_strobe = 1'b0;
            m_chan   = 2'd0;
            m_ovr    = 1'b0;
            m_fs     = 1'b0;
            m_fc     = 16'h0;
        end else begin
            if (m_valid[m_ptr]) begin
                m_data   = m_hold[m_ptr];
                m_chan   = 2'(m_ptr);
                m_strobe = 1'b1;
                m_valid[m_ptr] = 1'b0;
                m_fs     = (m_ptr == lowest(m_mask));
                if (m_fs) m_fc = m_fc + 16'h1;
                m_ptr    = next_act(m_ptr, m_mask);
            end else begin
                m_strobe = 1'b0;
                m_fs     = 1'b0;
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (strobe_in[ch] && m_mask[ch]) begin
                    if (m_valid[ch]) m_ovr = 1'b1;
                    m_valid[ch] = 1'b1;
                    m_hold[ch]  = data_in[ch*DW +: DW];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("data_out", data_out, m_data);
        chk("strobe_out", strobe_out, m_strobe);
        chk("chan_out", chan_out, m_chan);
        chk("overrun", overrun, m_ovr);
`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
        chk("frame_start", frame_start, m_fs);
        chk("frame_count", frame_count, m_fc);
`endif
        strobe_in = 4'b0;
        init      = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [15:0] v);
        strobe_in[ch] = 1'b1;
        data_in[ch*DW +: DW] = v;
    endtask

    task automatic do_init(input logic [3:0] m);
        active_mask = m;
        init = 1'b1;
        step();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; init = 1'b0;
        active_mask = 4'b0; strobe_in = 4'b0; data_in = '0;
        m_hold[0] = 16'h0; m_hold[1] = 16'h0; m_hold[2] = 16'h0; m_hold[3] = 16'h0;
        step();
        step();
        chk("rst_data", data_out, 32'h0);
        chk("rst_strobe", strobe_out, 32'h0);
        chk("rst_ovr", overrun, 32'h0);
        reset_n = 1'b1;

        // Two channels strobing together emit in channel order
        do_init(4'b0011);
        strobe(0, 16'h1111); strobe(1, 16'h2222);
        step();
        chk("s1_no_early", strobe_out, 32'h0);
        step();
        chk("s1_d0", data_out, 32'h1111); chk("s1_c0", chan_out, 32'h0); chk("s1_s0", strobe_out, 32'h1);
        step();
        chk("s1_d1", data_out, 32'h2222); chk("s1_c1", chan_out, 32'h1); chk("s1_ovr", overrun, 32'h0);

        // Later channel waits for the stalled lower channel
        do_init(4'b0101);
        strobe(2, 16'h3333);
        step();
        repeat (3) begin
            step();
            chk("s2_blocked", strobe_out, 32'h0);
        end
        strobe(0, 16'h4444);
        step();
        chk("s2_lat", strobe_out, 32'h0);
        step();
        chk("s2_d0", data_out, 32'h4444); chk("s2_c0", chan_out, 32'h0);
        step();
        chk("s2_d2", data_out, 32'h3333); chk("s2_c2", chan_out, 32'h2);

        // Single channel acts as a one-cycle register
        do_init(4'b0001);
        for (int v = 1; v <= 3; v++) begin
            strobe(0, 16'(v));
            step();
            if (v > 1) chk("s3_pass", data_out, 32'(v - 1));
        end
        step();
        chk("s3_last", data_out, 32'h3);
        chk("s3_ovr", overrun, 32'h0);

        // Overrun on a channel blocked behind channel 0
        do_init(4'b0011);
        strobe(1, 16'hAAAA); step();
        strobe(1, 16'hBBBB); step();
        chk("s4_ovr", overrun, 32'h1);
        strobe(0, 16'h5555); step();
        step();
        chk("s4_d0", data_out, 32'h5555); chk("s4_c0", chan_out, 32'h0);
        step();
        chk("s4_d1", data_out, 32'hBBBB); chk("s4_c1", chan_out, 32'h1);
        chk("s4_sticky", overrun, 32'h1);

        // Init drops pending data and switches mask
        strobe(1, 16'hCCCC); step();
        do_init(4'b1000);
        chk("s5_init_strobe", strobe_out, 32'h0);
        chk("s5_init_ovr", overrun, 32'h0);
        strobe(3, 16'h7777); step();
        step();
        chk("s5_d3", data_out, 32'h7777); chk("s5_c3", chan_out, 32'h3); chk("s5_s3", strobe_out, 32'h1);
        step();
        chk("s5_dropped", strobe_out, 32'h0);
        do_init(4'b0011);
        strobe(1, 16'h0001); step();
        strobe(1, 16'h0002); step();
        chk("s5_ovr_set", overrun, 32'h1);
        reset_n = 1'b0; step();
        chk("s5_rst_ovr", overrun, 32'h0);
        reset_n = 1'b1;

        // Empty mask ignores everything
        do_init(4'b0000);
        repeat (3) begin
            strobe_in = 4'hF; data_in = {$urandom, $urandom};
            step();
            chk("s6_empty", strobe_out, 32'h0);
        end
        chk("s6_empty_ovr", overrun, 32'h0);

`ifdef CHAN_INTERLEAVE_SCHED_FRAME_EN
        do_init(4'b0110);
        for (int f = 1; f <= 3; f++) begin
            strobe(1, 16'(f)); strobe(2, 16'(f + 256));
            step();
            step();
            chk("fr_start", frame_start, 32'h1); chk("fr_count", frame_count, 32'(f));
            chk("fr_chan1", chan_out, 32'h1);
            step();
            chk("fr_nostart", frame_start, 32'h0); chk("fr_chan2", chan_out, 32'h2);
        end
`endif

        // Randomized traffic with occasional init, disable and reset
        for (int r = 0; r < 20; r++) begin
            do_init(4'($urandom));
            for (int c = 0; c < 100; c++) begin
                strobe_in = 4'($urandom) & 4'($urandom);
                data_in   = {$urandom, $urandom};
                enable    = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 59) == 0) begin
                    active_mask = 4'($urandom);
                    init = 1'b1;
                end
                reset_n = ($urandom_range(0, 99) != 0);
                step();
            end
            enable = 1'b1;
            reset_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
